// File: rtl/trap_shaper_mc.sv
// trap_shaper_mc: trapezoidal pulse shaper with runtime-loadable K, L and M.
// Six-stage valid-qualified pipeline, saturated output, synchronous reset.
// Optional peak detector is built when TRAP_PEAK_DETECT_EN is defined;
// otherwise peak_valid/peak_data are tied low and cfg_thr is ignored.
module trap_shaper_mc #(
    parameter int ADC_W     = 12,
    parameter int OUT_W     = 16,
    parameter int DEPTH_MAX = 64,
    parameter int M_W       = 8,
    parameter int SHIFT     = 4,
    parameter int K_DEF     = 4,
    parameter int L_DEF     = 8,
    parameter int M_DEF     = 0,
    parameter int THR_DEF   = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [ADC_W-1:0]             in_data,
    input  logic                         cfg_we,
    input  logic [$clog2(DEPTH_MAX)-1:0] cfg_k,
    input  logic [$clog2(DEPTH_MAX)-1:0] cfg_l,
    input  logic [M_W-1:0]               cfg_m,
    input  logic signed [OUT_W-1:0]      cfg_thr,
    output logic                         cfg_err,
    output logic                         out_valid,
    output logic signed [OUT_W-1:0]      out_data,
    output logic                         out_sat,
    output logic                         peak_valid,
    output logic signed [OUT_W-1:0]      peak_data
);

    localparam int AW    = $clog2(DEPTH_MAX);
    localparam int ACC_W = ADC_W + M_W + 2 * AW + 4;

    localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    // ------------------------------------------------------------------
    // Configuration
    // ------------------------------------------------------------------
    logic [AW-1:0]  k_q;
    logic [AW-1:0]  l_q;
    logic [M_W-1:0] m_q;
    logic           cfg_err_q;

    logic [AW:0]    kl_sum;
    logic           cfg_ok;
    logic           flush;
    logic           sample_in;

    // Validate a write request; an accepted write also flushes the datapath
    always_comb begin
        kl_sum    = {1'b0, cfg_k} + {1'b0, cfg_l};
        cfg_ok    = (cfg_k != '0) && (cfg_k <= cfg_l) &&
                    (kl_sum <= (AW+1)'(DEPTH_MAX - 1));
        flush     = cfg_we && cfg_ok;
        sample_in = in_valid && !flush;
    end

    // Configuration registers: defaults on reset, loaded only by a legal write
    always_ff @(posedge clk) begin
        if (reset) begin
            k_q <= AW'(K_DEF);
            l_q <= AW'(L_DEF);
            m_q <= M_W'(M_DEF);
        end else if (flush) begin
            k_q <= cfg_k;
            l_q <= cfg_l;
            m_q <= cfg_m;
        end
    end

    // Rejected-write indicator, a single-cycle pulse after the bad request
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_we && !cfg_ok;
        end
    end

    // ------------------------------------------------------------------
    // Delay line
    // ------------------------------------------------------------------
    logic [ADC_W-1:0] dline_q [DEPTH_MAX];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    tap_k;
    logic [AW-1:0]    tap_l;
    logic [AW-1:0]    tap_kl;

    // Tap addresses wrap naturally because the pointer is exactly AW bits
    always_comb begin
        tap_k  = wptr_q - k_q;
        tap_l  = wptr_q - l_q;
        tap_kl = wptr_q - k_q - l_q;
    end

    // Circular sample history, advanced only by accepted samples
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int i = 0; i < DEPTH_MAX; i++) begin
                dline_q[i] <= '0;
            end
            wptr_q <= '0;
        end else if (sample_in) begin
            dline_q[wptr_q] <= in_data;
            wptr_q          <= wptr_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Pipeline stage registers
    // ------------------------------------------------------------------
    logic                    v1_q, v2_q, v3_q, v4_q, v5_q, v6_q;
    logic [ADC_W-1:0]        x0_q, xk_q, xl_q, xkl_q;
    logic signed [ACC_W-1:0] d_q, d1_q, d2_q;
    logic signed [ACC_W-1:0] p_q, md2_q, r_q, s_q;
    logic signed [OUT_W-1:0] out_data_q;
    logic                    out_sat_q;

    logic signed [ACC_W-1:0] x0_ext, xk_ext, xl_ext, xkl_ext, m_ext;
    logic signed [ACC_W-1:0] md2_d;

    // Zero-extend the unsigned samples and M into the signed accumulator width
    always_comb begin
        x0_ext  = {{(ACC_W-ADC_W){1'b0}}, x0_q};
        xk_ext  = {{(ACC_W-ADC_W){1'b0}}, xk_q};
        xl_ext  = {{(ACC_W-ADC_W){1'b0}}, xl_q};
        xkl_ext = {{(ACC_W-ADC_W){1'b0}}, xkl_q};
        m_ext   = {{(ACC_W-M_W){1'b0}}, m_q};
        md2_d   = m_ext * d2_q;
    end

    // Stage 1: capture the new sample together with its three delayed taps
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            v1_q  <= 1'b0;
            x0_q  <= '0;
            xk_q  <= '0;
            xl_q  <= '0;
            xkl_q <= '0;
        end else begin
            v1_q <= sample_in;
            if (sample_in) begin
                x0_q  <= in_data;
                xk_q  <= dline_q[tap_k];
                xl_q  <= dline_q[tap_l];
                xkl_q <= dline_q[tap_kl];
            end
        end
    end

    // Stage 2: the two K-differences, current and L-delayed
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            v2_q <= 1'b0;
            d_q  <= '0;
            d1_q <= '0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                d_q  <= x0_ext - xk_ext;
                d1_q <= xl_ext - xkl_ext;
            end
        end
    end

    // Stage 3: combined trapezoid difference
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            v3_q <= 1'b0;
            d2_q <= '0;
        end else begin
            v3_q <= v2_q;
            if (v2_q) begin
                d2_q <= d_q - d1_q;
            end
        end
    end

    // Stage 4: first accumulator plus the pole-zero product M*d2
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            v4_q  <= 1'b0;
            p_q   <= '0;
            md2_q <= '0;
        end else begin
            v4_q <= v3_q;
            if (v3_q) begin
                p_q   <= p_q + d2_q;
                md2_q <= md2_d;
            end
        end
    end

    // Stage 5: deconvolved term from the freshly updated accumulator
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            v5_q <= 1'b0;
            r_q  <= '0;
        end else begin
            v5_q <= v4_q;
            if (v4_q) begin
                r_q <= p_q + md2_q;
            end
        end
    end

    logic signed [ACC_W-1:0] s_d;
    logic signed [ACC_W-1:0] s_shift;
    logic [ACC_W-OUT_W:0]    s_top;
    logic                    s_fits;
    logic signed [OUT_W-1:0] out_d;
    logic                    sat_d;

    // Second accumulator, scaling shift and saturation to the output range
    always_comb begin
        s_d     = s_q + r_q;
        s_shift = s_d >>> SHIFT;
        s_top   = s_shift[ACC_W-1:OUT_W-1];
        s_fits  = (s_top == '0) || (s_top == '1);
        out_d   = s_shift[OUT_W-1:0];
        sat_d   = 1'b0;
        if (!s_fits) begin
            out_d = s_shift[ACC_W-1] ? OUT_MIN : OUT_MAX;
            sat_d = 1'b1;
        end
    end

    // Stage 6: commit the accumulator and register the saturated output
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            v6_q       <= 1'b0;
            s_q        <= '0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
        end else begin
            v6_q <= v5_q;
            if (v5_q) begin
                s_q        <= s_d;
                out_data_q <= out_d;
                out_sat_q  <= sat_d;
            end
        end
    end

    assign cfg_err   = cfg_err_q;
    assign out_valid = v6_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

    // ------------------------------------------------------------------
    // Peak detector
    // ------------------------------------------------------------------
`ifdef TRAP_PEAK_DETECT_EN
    typedef enum logic {
        PK_IDLE,
        PK_ARMED
    } pk_state_e;

    pk_state_e               pk_state_q, pk_state_d;
    logic signed [OUT_W-1:0] thr_q;
    logic signed [OUT_W-1:0] max_q, max_d;
    logic signed [OUT_W-1:0] peak_data_q, peak_data_d;
    logic                    peak_valid_q, peak_valid_d;

    // Threshold follows the same load rules as the other configuration
    always_ff @(posedge clk) begin
        if (reset) begin
            thr_q <= OUT_W'(THR_DEF);
        end else if (flush) begin
            thr_q <= cfg_thr;
        end
    end

    // Peak state register; a flush drops any partially tracked pulse
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            pk_state_q   <= PK_IDLE;
            max_q        <= '0;
            peak_valid_q <= 1'b0;
            peak_data_q  <= '0;
        end else begin
            pk_state_q   <= pk_state_d;
            max_q        <= max_d;
            peak_valid_q <= peak_valid_d;
            peak_data_q  <= peak_data_d;
        end
    end

    // Arm above threshold, track the maximum, report once it drops below
    always_comb begin
        pk_state_d   = pk_state_q;
        max_d        = max_q;
        peak_valid_d = 1'b0;
        peak_data_d  = peak_data_q;
        if (v6_q) begin
            case (pk_state_q)
                PK_IDLE: begin
                    if (out_data_q > thr_q) begin
                        pk_state_d = PK_ARMED;
                        max_d      = out_data_q;
                    end
                end
                PK_ARMED: begin
                    if (out_data_q > max_q) begin
                        max_d = out_data_q;
                    end
                    if (out_data_q < thr_q) begin
                        peak_valid_d = 1'b1;
                        peak_data_d  = max_q;
                        pk_state_d   = PK_IDLE;
                    end
                end
                default: begin
                    pk_state_d = PK_IDLE;
                end
            endcase
        end
    end

    assign peak_valid = peak_valid_q;
    assign peak_data  = peak_data_q;
`else
    logic unused_cfg_thr;
    assign unused_cfg_thr = ^cfg_thr;
    assign peak_valid     = 1'b0;
    assign peak_data      = '0;
`endif

endmodule

// File: tb/tb_trap_shaper_mc.sv
// tb_trap_shaper_mc: scoreboard bench for trap_shaper_mc.
// Drivers push expected outputs into queues; a negedge monitor pops and compares.
module tb_trap_shaper_mc;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic [11:0]       in_data = '0;
    logic              cfg_we = 1'b0;
    logic [5:0]        cfg_k = '0;
    logic [5:0]        cfg_l = '0;
    logic [7:0]        cfg_m = '0;
    logic signed [15:0] cfg_thr = '0;
    logic              cfg_err;
    logic              out_valid;
    logic signed [15:0] out_data;
    logic              out_sat;
    logic              peak_valid;
    logic signed [15:0] peak_data;

    typedef struct {
        logic signed [15:0] data;
        logic               sat;
    } exp_t;

    exp_t expQ[$];
    int   peakQ[$];
    int   checksTotal = 0;
    int   checksPassed = 0;
    int   unusedPeaks = 0;

    // Direct-form reference: sample history plus the two running sums
    int     xs[$];
    longint mp = 0;
    longint ms = 0;
    int     mk = 4;
    int     ml = 8;
    int     mm = 0;

    int impulseTable [12] = '{6, 12, 18, 25, 25, 25, 25, 25, 18, 12, 6, 0};
    int k23Table     [6]  = '{10, 20, 20, 10, 0, 0};
    int k23m2Table   [7]  = '{30, 40, 20, -10, -20, 0, 0};

    trap_shaper_mc dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .cfg_we     (cfg_we),
        .cfg_k      (cfg_k),
        .cfg_l      (cfg_l),
        .cfg_m      (cfg_m),
        .cfg_thr    (cfg_thr),
        .cfg_err    (cfg_err),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_sat    (out_sat),
        .peak_valid (peak_valid),
        .peak_data  (peak_data)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checksTotal++;
        if (actual == expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic longint xAt(input int i);
        if (i < 0) return 0;
        return longint'(xs[i]);
    endfunction

    task automatic modelReset(input int k, input int l, input int m);
        xs.delete();
        mp = 0;
        ms = 0;
        mk = k;
        ml = l;
        mm = m;
    endtask

    task automatic modelStep(input int x, output logic signed [15:0] od, output logic osat);
        longint d, d1, d2, r, sh;
        int n;
        xs.push_back(x);
        n  = xs.size() - 1;
        d  = xAt(n) - xAt(n - mk);
        d1 = xAt(n - ml) - xAt(n - mk - ml);
        d2 = d - d1;
        mp = mp + d2;
        r  = mp + longint'(mm) * d2;
        ms = ms + r;
        sh = ms >>> 4;
        if (sh > 32767) begin
            od   = 16'h7fff;
            osat = 1'b1;
        end else if (sh < -32768) begin
            od   = 16'h8000;
            osat = 1'b1;
        end else begin
            od   = 16'(sh);
            osat = 1'b0;
        end
    endtask

    task automatic expectPeak(input int v);
`ifdef TRAP_PEAK_DETECT_EN
        peakQ.push_back(v);
`else
        unusedPeaks += v;
`endif
    endtask

    // One clock of stimulus; a valid sample queues its expected output
    task automatic applyStimulus(input bit v, input int x, input bit useTable, input int tableVal);
        exp_t e;
        logic signed [15:0] md;
        logic msat;
        in_valid = v;
        in_data  = 12'(x);
        if (v) begin
            modelStep(x, md, msat);
            if (useTable) begin
                e.data = 16'(tableVal);
                e.sat  = 1'b0;
            end else begin
                e.data = md;
                e.sat  = msat;
            end
            expQ.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic runImpulse(input int gap);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, (i == 0) ? 100 : 0, 1'b1, impulseTable[i]);
            if (gap == 0 && i <= 6) checkOutput("latency_out_valid", out_valid, (i >= 5) ? 1 : 0);
            for (int g = 0; g < gap; g++) applyStimulus(1'b0, 0, 1'b0, 0);
        end
    endtask

    task automatic cfgWrite(input int k, input int l, input int m, input int thr,
                            input bit expectErr, input bit inV, input int inX);
        cfg_we   = 1'b1;
        cfg_k    = 6'(k);
        cfg_l    = 6'(l);
        cfg_m    = 8'(m);
        cfg_thr  = 16'(thr);
        in_valid = inV;
        in_data  = 12'(inX);
        @(posedge clk);
        #1;
        cfg_we   = 1'b0;
        in_valid = 1'b0;
        checkOutput("cfg_err", cfg_err, expectErr ? 1 : 0);
        if (!expectErr) begin
            expQ.delete();
            peakQ.delete();
            modelReset(k, l, m);
            checkOutput("flush_out_valid", out_valid, 0);
            checkOutput("flush_out_data", out_data, 0);
        end
        @(posedge clk);
        #1;
        checkOutput("cfg_err_single_cycle", cfg_err, 0);
    endtask

    task automatic doReset(input bit withCfg);
        reset    = 1'b1;
        in_valid = 1'b0;
        if (withCfg) begin
            cfg_we  = 1'b1;
            cfg_k   = 6'd2;
            cfg_l   = 6'd3;
            cfg_m   = 8'd5;
            cfg_thr = 16'sd100;
        end
        @(posedge clk);
        #1;
        reset  = 1'b0;
        cfg_we = 1'b0;
        expQ.delete();
        peakQ.delete();
        modelReset(4, 8, 0);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_out_data", out_data, 0);
        checkOutput("reset_out_sat", out_sat, 0);
        checkOutput("reset_peak_valid", peak_valid, 0);
        checkOutput("reset_peak_data", peak_data, 0);
        checkOutput("reset_cfg_err", cfg_err, 0);
    endtask

    task automatic waitDrain();
        int guard = 0;
        while (expQ.size() != 0 && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        checkOutput("drain_outputs", expQ.size(), 0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checkOutput("drain_peaks", peakQ.size(), 0);
    endtask

    // Monitor: every presented output or peak must match the queue head
    always @(negedge clk) begin : monitor
        exp_t e;
        int   pk;
        if (!reset) begin
            if (out_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_out_valid", out_data, -99999);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("out_data", out_data, e.data);
                    checkOutput("out_sat", out_sat, e.sat);
                end
            end
            if (peak_valid) begin
                if (peakQ.size() == 0) begin
                    checkOutput("unexpected_peak_valid", peak_data, -99999);
                end else begin
                    pk = peakQ.pop_front();
                    checkOutput("peak_data", peak_data, pk);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete, passed %0d of %0d", checksPassed, checksTotal);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        repeat (2) @(posedge clk);
        #1;
        doReset(1'b0);

        // Back-to-back impulse with default configuration
        expectPeak(25);
        runImpulse(0);
        waitDrain();

        // Same impulse with in_valid on every third clock
        expectPeak(25);
        runImpulse(2);
        waitDrain();

        // Illegal writes interleaved with a pulse leave everything untouched
        expectPeak(25);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, (i == 0) ? 100 : 0, 1'b1, impulseTable[i]);
            if (i == 3) cfgWrite(10, 5, 0, 10, 1'b1, 1'b0, 0);
            if (i == 5) cfgWrite(40, 30, 0, 10, 1'b1, 1'b0, 0);
            if (i == 7) cfgWrite(0, 5, 0, 10, 1'b1, 1'b0, 0);
            if (i == 8) cfgWrite(32, 32, 0, 10, 1'b1, 1'b0, 0);
        end
        waitDrain();

        // Largest legal K+L uses the full delay-line span
        cfgWrite(31, 32, 0, 10, 1'b0, 1'b0, 0);
        expectPeak(31);
        applyStimulus(1'b1, 16, 1'b0, 0);
        for (int i = 0; i < 70; i++) applyStimulus(1'b1, 0, 1'b0, 0);
        waitDrain();

        // Legal write while a pulse is armed: flush, drop same-cycle sample
        cfgWrite(4, 8, 0, 10, 1'b0, 1'b0, 0);
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, (i == 0) ? 100 : 0, 1'b1, impulseTable[i]);
        cfgWrite(2, 3, 0, 10, 1'b0, 1'b1, 500);
        expectPeak(20);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, (i == 0) ? 160 : 0, 1'b1, k23Table[i]);
        waitDrain();

        // Pole-zero term drives the response negative
        cfgWrite(2, 3, 2, 10, 1'b0, 1'b0, 0);
        expectPeak(40);
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, (i == 0) ? 160 : 0, 1'b1, k23m2Table[i]);
        waitDrain();

        // Full-scale step saturates positive and stays there
        cfgWrite(20, 40, 0, 10, 1'b0, 1'b0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 0, 1'b0, 0);
        for (int i = 0; i < 2000; i++) applyStimulus(1'b1, 4095, 1'b0, 0);
        waitDrain();

        // Reset while armed, together with a legal write, restores defaults
        doReset(1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, (i == 0) ? 100 : 0, 1'b1, impulseTable[i]);
        doReset(1'b1);
        expectPeak(25);
        runImpulse(0);
        waitDrain();

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
